// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation stage: format codes and
// the skid-buffer state encoding.
package imm_pkg;

  localparam logic [2:0] EXT_I     = 3'b000;
  localparam logic [2:0] EXT_B     = 3'b001;
  localparam logic [2:0] EXT_U     = 3'b010;
  localparam logic [2:0] EXT_JAL   = 3'b011;
  localparam logic [2:0] EXT_S     = 3'b100;
  localparam logic [2:0] EXT_Z     = 3'b101;
  localparam logic [2:0] EXT_SHAMT = 3'b110;
  localparam logic [2:0] EXT_RSV   = 3'b111;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: picks one of the RV immediate formats
// and widens it to XLEN (sign- or zero-extended depending on the format).
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instruction,
  input  logic [2:0]      i_sext_type,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;
  logic        w_zext;
  logic [31:0] w_i;

  assign w_i = i_instruction;

  always_comb begin
    w_imm32 = 32'd0;
    w_zext  = 1'b0;
    case (i_sext_type)
      EXT_B:     w_imm32 = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
      EXT_U:     w_imm32 = {w_i[31:12], 12'd0};
      EXT_JAL:   w_imm32 = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      EXT_S:     w_imm32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
      EXT_Z: begin
        w_zext  = 1'b1;
        w_imm32 = {27'd0, w_i[19:15]};
      end
      EXT_SHAMT: begin
        w_zext  = 1'b1;
        // RV64 shift amounts carry a sixth bit in instr[25]
        w_imm32 = (XLEN == 64) ? {26'd0, w_i[25:20]} : {27'd0, w_i[24:20]};
      end
      default:   w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
    endcase
  end

  assign o_imm = w_zext ? XLEN'(w_imm32) : XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-generation stage with optional PC-relative target,
// 2-entry skid buffer (registered in_ready) and synchronous flush.
module imm_ext_stage
  import imm_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit PC_TARGET = 1'b1,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [2:0]       sext_type,
  input  logic [XLEN-1:0]  pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_D,
  output logic [XLEN-1:0]  target,
  output logic [TAG_W-1:0] out_tag
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_main_imm;
  logic [XLEN-1:0]  r_main_tgt;
  logic [TAG_W-1:0] r_main_tag;
  logic [XLEN-1:0]  r_skid_imm;
  logic [XLEN-1:0]  r_skid_tgt;
  logic [TAG_W-1:0] r_skid_tag;

  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_tgt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .i_instruction(instruction),
    .i_sext_type  (sext_type),
    .o_imm        (w_imm)
  );

  generate
    if (PC_TARGET) begin : g_target
      assign w_tgt = pc + w_imm;
    end else begin : g_no_target
      logic w_unused_pc;
      assign w_unused_pc = ^pc;
      assign w_tgt       = '0;
    end
  endgenerate

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_comb begin
    w_state_next   = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      // Anything accepted this cycle is dropped; a concurrent output
      // handshake has already been seen downstream.
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_next = S_ONE;
            w_load_main  = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
          end else if (w_in_fire) begin
            w_state_next = S_TWO;
            w_load_skid  = 1'b1;
          end else if (w_out_fire) begin
            w_state_next = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_fire) begin
            w_state_next   = S_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != S_TWO);
      r_out_valid <= (w_state_next != S_EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_imm <= '0;
      r_main_tgt <= '0;
      r_main_tag <= '0;
    end else if (w_load_main) begin
      r_main_imm <= w_imm;
      r_main_tgt <= w_tgt;
      r_main_tag <= in_tag;
    end else if (w_skid_to_main) begin
      r_main_imm <= r_skid_imm;
      r_main_tgt <= r_skid_tgt;
      r_main_tag <= r_skid_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_imm <= '0;
      r_skid_tgt <= '0;
      r_skid_tag <= '0;
    end else if (w_load_skid) begin
      r_skid_imm <= w_imm;
      r_skid_tgt <= w_tgt;
      r_skid_tag <= in_tag;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign imm_D     = r_main_imm;
  assign target    = r_main_tgt;
  assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: one XLEN=32 and one XLEN=64 instance,
// inputs driven and outputs sampled on the falling clock edge.
module tb_imm_ext_stage;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_instr, a_pc, a_imm, a_tgt;
  logic [2:0]  a_sext;
  logic [4:0]  a_in_tag, a_out_tag;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_instr;
  logic [63:0] b_pc, b_imm, b_tgt;
  logic [2:0]  b_sext;
  logic [4:0]  b_in_tag, b_out_tag;

  int checks = 0;
  int errors = 0;

  imm_ext_stage #(.XLEN(32), .PC_TARGET(1'b1), .TAG_W(5)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instruction(a_instr), .sext_type(a_sext), .pc(a_pc), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .imm_D(a_imm), .target(a_tgt), .out_tag(a_out_tag)
  );

  imm_ext_stage #(.XLEN(64), .PC_TARGET(1'b1), .TAG_W(5)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instruction(b_instr), .sext_type(b_sext), .pc(b_pc), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .imm_D(b_imm), .target(b_tgt), .out_tag(b_out_tag)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_instr = 0; a_sext = 0; a_pc = 0; a_in_tag = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_instr = 0; b_sext = 0; b_pc = 0; b_in_tag = 0;
    #7;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_imm !== 32'd0 || a_tgt !== 32'd0 || a_out_tag !== 5'd0) begin
      errors++;
      $display("FAIL reset32 got v=%b r=%b imm=%h tgt=%h tag=%0d exp v=0 r=1 imm=0 tgt=0 tag=0",
               a_out_valid, a_in_ready, a_imm, a_tgt, a_out_tag);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_imm !== 64'd0 || b_tgt !== 64'd0 || b_out_tag !== 5'd0) begin
      errors++;
      $display("FAIL reset64 got v=%b r=%b imm=%h tgt=%h tag=%0d exp v=0 r=1 imm=0 tgt=0 tag=0",
               b_out_valid, b_in_ready, b_imm, b_tgt, b_out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_basic32;
    logic [31:0] v_instr [3];
    logic [2:0]  v_type  [3];
    logic [31:0] v_imm   [3];
    logic [31:0] v_tgt   [3];
    v_instr = '{32'hFFF00093, 32'hFE000EE3, 32'hFE20AC23};
    v_type  = '{EXT_I, EXT_B, EXT_S};
    v_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8};
    v_tgt   = '{32'h000000FF, 32'h000000FC, 32'h000000F8};
    a_pc = 32'h100; a_out_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_imm !== v_imm[i-1] || a_tgt !== v_tgt[i-1] || a_out_tag !== 5'(i)) begin
          errors++;
          $display("FAIL basic32[%0d] got v=%b imm=%h tgt=%h tag=%0d exp v=1 imm=%h tgt=%h tag=%0d",
                   i-1, a_out_valid, a_imm, a_tgt, a_out_tag, v_imm[i-1], v_tgt[i-1], i);
        end
        $display("basic32: vector %0d imm=%h tgt=%h", i-1, a_imm, a_tgt);
      end
      if (i < 3) begin
        a_in_valid = 1'b1; a_instr = v_instr[i]; a_sext = v_type[i]; a_in_tag = 5'(i+1);
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic32_drain got v=%b exp v=0", a_out_valid);
    end
  endtask

  task automatic test_xlen64;
    logic [31:0] v_instr [3];
    logic [2:0]  v_type  [3];
    logic [63:0] v_imm   [3];
    logic [63:0] v_tgt   [3];
    v_instr = '{32'h800000B7, 32'h02A0D093, 32'h3401F073};
    v_type  = '{EXT_U, EXT_SHAMT, EXT_Z};
    v_imm   = '{64'hFFFFFFFF80000000, 64'h2A, 64'h3};
    v_tgt   = '{64'hFFFFFFFF80001000, 64'h102A, 64'h1003};
    b_pc = 64'h1000; b_out_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_imm !== v_imm[i-1] || b_tgt !== v_tgt[i-1] || b_out_tag !== 5'(i)) begin
          errors++;
          $display("FAIL xlen64[%0d] got v=%b imm=%h tgt=%h tag=%0d exp v=1 imm=%h tgt=%h tag=%0d",
                   i-1, b_out_valid, b_imm, b_tgt, b_out_tag, v_imm[i-1], v_tgt[i-1], i);
        end
        $display("xlen64: vector %0d imm=%h tgt=%h", i-1, b_imm, b_tgt);
      end
      if (i < 3) begin
        b_in_valid = 1'b1; b_instr = v_instr[i]; b_sext = v_type[i]; b_in_tag = 5'(i+1);
      end else begin
        b_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL xlen64_drain got v=%b exp v=0", b_out_valid);
    end
  endtask

  task automatic test_backpressure;
    int   next_in;
    int   exp_out;
    logic acc;
    logic del;
    next_in = 1; exp_out = 1;
    a_pc = 32'h100; a_instr = 32'hFFF00093; a_sext = EXT_I;
    for (int cyc = 0; cyc < 40; cyc++) begin
      a_in_valid  = (next_in <= 6);
      a_in_tag    = 5'(next_in);
      a_out_ready = (cyc >= 4);
      acc = a_in_valid && a_in_ready;
      del = a_out_valid && a_out_ready;
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_tag !== 5'd1) begin
          errors++;
          $display("FAIL bp_hold cyc=%0d got v=%b tag=%0d exp v=1 tag=1", cyc, a_out_valid, a_out_tag);
        end
        checks++;
        if (a_in_ready !== (cyc == 1)) begin
          errors++;
          $display("FAIL bp_in_ready cyc=%0d got %b exp %b", cyc, a_in_ready, (cyc == 1));
        end
      end
      if (cyc >= 4 && exp_out <= 6) begin
        checks++;
        if (a_out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_gap cyc=%0d got v=%b exp v=1 (waiting for tag %0d)", cyc, a_out_valid, exp_out);
        end
      end
      if (del) begin
        checks++;
        if (a_out_tag !== 5'(exp_out)) begin
          errors++;
          $display("FAIL bp_order got tag=%0d exp tag=%0d", a_out_tag, exp_out);
        end
        $display("backpressure: delivered tag %0d", a_out_tag);
        exp_out++;
      end
      if (exp_out > 6) break;
      @(negedge clk);
      if (acc) next_in++;
    end
    checks++;
    if (exp_out != 7) begin
      errors++;
      $display("FAIL bp_timeout got %0d deliveries exp 6", exp_out - 1);
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_dup got v=%b tag=%0d exp v=0", a_out_valid, a_out_tag);
    end
  endtask

  task automatic test_flush;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_instr = 32'hFFF00093; a_sext = EXT_I; a_in_tag = 5'd7;
    @(negedge clk);
    a_in_tag = 5'd8;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup got r=%b v=%b exp r=0 v=1", a_in_ready, a_out_valid);
    end
    a_flush = 1'b1; a_in_tag = 5'd10;
    @(negedge clk);
    a_flush = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_two got v=%b r=%b exp v=0 r=1", a_out_valid, a_in_ready);
    end
    a_in_tag = 5'd9; a_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 5'd9) begin
      errors++;
      $display("FAIL flush_next got v=%b tag=%0d exp v=1 tag=9", a_out_valid, a_out_tag);
    end
    $display("flush: first entry after flush tag %0d", a_out_tag);
    // flush in ONE while both handshakes fire: the new input must vanish
    a_flush = 1'b1; a_in_tag = 5'd11;
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_one got v=%b r=%b exp v=0 r=1", a_out_valid, a_in_ready);
    end
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard got v=%b tag=%0d exp v=0", a_out_valid, a_out_tag);
    end
  endtask

  task automatic test_wrap;
    a_pc = 32'hFFFFFFFC; a_instr = 32'h0080006F; a_sext = EXT_JAL; a_in_tag = 5'd5;
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_imm !== 32'h8 || a_tgt !== 32'h4 || a_out_tag !== 5'd5) begin
      errors++;
      $display("FAIL wrap got v=%b imm=%h tgt=%h tag=%0d exp v=1 imm=00000008 tgt=00000004 tag=5",
               a_out_valid, a_imm, a_tgt, a_out_tag);
    end
    $display("wrap: imm=%h tgt=%h", a_imm, a_tgt);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    a_pc = 32'h100; a_instr = 32'hFFF00093; a_sext = EXT_I; a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_tag = 5'd3;
    @(negedge clk);
    a_in_tag = 5'd4;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_imm !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL rstmid_setup got v=%b r=%b imm=%h exp v=1 r=0 imm=ffffffff", a_out_valid, a_in_ready, a_imm);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_imm !== 32'd0 || a_tgt !== 32'd0 || a_out_tag !== 5'd0) begin
      errors++;
      $display("FAIL rstmid got v=%b r=%b imm=%h tgt=%h tag=%0d exp v=0 r=1 imm=0 tgt=0 tag=0",
               a_out_valid, a_in_ready, a_imm, a_tgt, a_out_tag);
    end
    $display("reset_mid: asserted in TWO");
    @(negedge clk);
    rst_n = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_discard got v=%b tag=%0d exp v=0", a_out_valid, a_out_tag);
    end
  endtask

  initial begin
    test_reset();
    test_basic32();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
- Registered, parametrised immediate-generation stage sitting between instruction decode and the execute/branch units.
- Takes one instruction per cycle over a valid/ready handshake and extracts the immediate for one of seven formats, widened to XLEN.
- Optionally computes a PC-relative target (pc + imm) in the same stage.
- A 2-entry skid buffer gives full throughput with a registered in_ready. Synchronous flush handles branch redirects.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. All immediates are sign- or zero-extended to XLEN.
- PC_TARGET, 1, when 1 the target output is pc + imm; when 0 target is tied to 0 and the adder is not built.
- TAG_W, 5, width of the sideband tag carried alongside each instruction (e.g. rd or ROB index).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  stage can accept; registered.
- instruction  in  32  raw RV instruction.
- sext_type  in  3  immediate format select.
- pc  in  XLEN  instruction address.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- imm_D  out  XLEN  extended immediate.
- target  out  XLEN  pc + imm_D (or 0 when PC_TARGET=0).
- out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Format select (sext_type). Codes 0-3 keep the encodings of the existing extender.
  - 000 I: instr[31:20], sign-extended.
  - 001 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - 010 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - 100 S: {instr[31:25], instr[11:7]}, sign-extended.
  - 101 Z (CSR zimm): instr[19:15], zero-extended.
  - 110 SHAMT: instr[24:20] zero-extended when XLEN=32; instr[25:20] when XLEN=64.
  - 111: reserved; decoded as I.
- Target: pc + imm_D modulo 2^XLEN; overflow wraps silently. It is computed at input and registered with the entry, so it has the same latency as imm_D.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_valid, imm_D, target and out_tag are held stable while out_valid & !out_ready.
- Storage: a main register (drives the outputs) plus one skid register.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main valid, in_ready=1.
  - TWO: main and skid valid, in_ready=0.
- Transitions:
  - EMPTY + input -> ONE.
  - ONE + input + output -> ONE; the main register reloads with the new entry.
  - ONE + input, no output -> TWO; the new entry goes to the skid register.
  - ONE + output only -> EMPTY.
  - TWO + output -> ONE; the skid entry moves to main.
  - In TWO no input is accepted.
- Latency: 1 cycle from input transfer to out_valid. Sustained throughput is 1 per cycle when out_ready is held high.
- Ordering: strictly in order; entries are never dropped or duplicated except by flush.
- Flush:
  - Next state is EMPTY, with out_valid=0 and in_ready=1.
  - An input presented in the flush cycle is discarded even if in_valid & in_ready.
  - An output handshake in the flush cycle still counts as delivered.
- Reset (async, rst_n low): state EMPTY, out_valid=0, in_ready=1, imm_D=0, target=0, out_tag=0, skid contents 0. Reset asserted mid-transfer discards all entries.
- Data registers load only on transfer. Outputs in EMPTY hold their last values, and downstream must ignore them.

Decomposition:
- Package imm_pkg:
  - sext_type localparams EXT_I, EXT_B, EXT_U, EXT_JAL, EXT_S, EXT_Z, EXT_SHAMT, EXT_RSV.
  - State encoding S_EMPTY/S_ONE/S_TWO.
- Sub-module imm_decode: purely combinational (instruction, sext_type) -> XLEN immediate, parametrised by XLEN. It is instantiated once at the stage input.
- imm_ext_stage holds the target adder, skid buffer, FSM and flush logic.

Test Plan:
- XLEN=32, pc=0x100, out_ready=1. Send three inputs and expect, 1 cycle later, these in order:
  - 0xFFF00093 type I -> imm_D=0xFFFFFFFF, target=0x000000FF.
  - 0xFE000EE3 type B -> imm_D=0xFFFFFFFC, target=0x000000FC.
  - 0xFE20AC23 type S -> imm_D=0xFFFFFFF8.
- XLEN=64: 0x800000B7 type U -> imm_D=0xFFFFFFFF80000000. 0x02A0D093 type SHAMT -> imm_D=0x2A. 0x3401F073 type Z -> imm_D=0x3.
- Backpressure: stream tags 1..6 back-to-back with out_ready low for 3 cycles.
  - in_ready must fall on the cycle after the second accept.
  - Outputs must hold tag 1 stable.
  - After out_ready rises, tags 1..6 must emerge in order with no gaps or duplicates.
- Flush in state TWO, with in_valid high that cycle:
  - Next cycle out_valid=0 and in_ready=1.
  - The next accepted entry, tag 9, is the first to appear.
- Reset: assert rst_n=0 asynchronously mid-cycle in state TWO. Immediately out_valid=0, in_ready=1, imm_D=0, target=0, out_tag=0.
- Wrap: XLEN=32, pc=0xFFFFFFFC, J-type immediate +8 -> target=0x00000004.
